ramrwp_fifoctl: RTL and testbench
=================================

Name: ramrwp_fifoctl

Overview:
Single-clock FIFO controller that acts as the master of an external two-port RAM macro. It drives the RAM's write port (wa/we/di) and read port (ra/re) and consumes its registered read data (1-cycle read latency). A 2-entry prefetch buffer gives a show-ahead pop interface. Pointer management ensures read and write never target the same address in the same cycle, so the RAM's collision checks never fire.

Parameters:
ADDRBIT, 9, RAM address width
DEPTH, 512, RAM entries; must be ≤ 2^ADDRBIT and ≥ 2
WIDTH, 32, data width

Ports:
clk  in  1  single clock for the block and the RAM (both RAM clocks tied to it)
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all pointers, counts and the prefetch buffer
push  in  1  write request
pdat  in  WIDTH  write data
full  out  1  RAM occupancy == DEPTH; a push while full is dropped
pop  in  1  consume the head entry; legal only while rd_vld
rd_vld  out  1  head entry is valid
rd_dat  out  WIDTH  head entry (show-ahead)
level  out  ADDRBIT+2  RAM occupancy + reads in flight + prefetch entries
ovf_err  out  1  sticky: push while full
udf_err  out  1  sticky: pop while !rd_vld
clr_err  in  1  clears both sticky errors
ram_wa  out  ADDRBIT  RAM write address
ram_we  out  1  RAM write enable
ram_di  out  WIDTH  RAM write data
ram_ra  out  ADDRBIT  RAM read address
ram_re  out  1  RAM read enable
ram_do  in  WIDTH  RAM read data, valid on the cycle after ram_re

Behaviour:
- Reset and flush values: all pointers 0; ram_cnt, inflight and pbuf_cnt 0; full, rd_vld, level 0; ram_we and ram_re 0; rd_dat 0; ovf_err and udf_err 0 (reset only, flush does not clear them). rst_n is asynchronous. flush has priority over push and pop in the same cycle.
- Write side is combinational to the RAM:
  - ram_we = push & !full & !flush
  - ram_wa = wptr; ram_di = pdat
  - wptr increments on ram_we and wraps from DEPTH-1 to 0. This is explicit wrap, not binary overflow, because DEPTH may be non-power-of-2.
- Read issue:
  - ram_re = (ram_cnt != 0) & ((pbuf_cnt + inflight - (pop & rd_vld)) < 2) & !flush
  - ram_ra = rptr; rptr wraps like wptr.
  - inflight is 1 on the cycle after ram_re.
- Prefetch buffer:
  - 2-entry FIFO, head = rd_dat.
  - While inflight, it loads ram_do at that cycle's clock edge. Load and pop in the same cycle are both honoured.
  - rd_vld = pbuf_cnt != 0.
- ram_cnt is updated by +ram_we and -ram_re; simultaneous push and read leaves it unchanged. full = (ram_cnt == DEPTH).
- Collision freedom is a requirement:
  - Read only when ram_cnt > 0 and write only when ram_cnt < DEPTH, so wptr == rptr with both enables high is unreachable.
  - Implement it as a simulation assertion: ram_re & ram_we & (ram_wa == ram_ra) → $display error.
- Latency:
  - Push at cycle N into an empty FIFO: write at edge N, ram_re in N+1, ram_do valid in N+2, rd_vld=1 in N+3.
  - Sustained push+pop throughput is 1 entry/cycle once primed.
- Boundaries:
  - Push while full: no write, ovf_err set, level unchanged.
  - Push while full with a read issued the same cycle: still dropped, because full is evaluated before the update.
  - Pop while !rd_vld: ignored, udf_err set.
  - clr_err and a new error in the same cycle: the error wins and the flag stays 1.
  - Maximum level = DEPTH + 2, which ADDRBIT+2 bits covers.
- Errors are sticky until clr_err or reset.

Decomposition:
- No typedef package; derived constants (count width = ADDRBIT+1, level width = ADDRBIT+2) are local parameters.
- One natural sub-module: ramrwp_pbuf, the 2-entry show-ahead register FIFO (load, pop, cnt, head data).

Test Plan:
- Reset: assert rst_n=0 mid-traffic → next cycle full=0, rd_vld=0, level=0, ram_we=0, ram_re=0, errors 0.
- Single push of 0xA5A5_0001 at cycle N into empty → ram_we with wa=0 at N; ram_re with ra=0 at N+1; rd_vld=1 and rd_dat=0xA5A5_0001 at N+3; pop → rd_vld=0, level=0.
- Fill with DEPTH+2 pushes and no pop → full=1 after the 514th accepted push (512 in RAM plus 2 prefetched); level=514; 515th push → ovf_err=1, no ram_we. Drain → data returns in order 0..513 and wptr/rptr wrap to 0.
- Continuous push+pop for 2000 cycles with random data → 1 pop/cycle after priming, in-order data, and the collision assertion never fires, including at wrap with DEPTH=5 (non-power-of-2 build).
- pop with rd_vld=0 → udf_err=1 and state unchanged; clr_err pulse → udf_err=0. clr_err with pop still illegal in the same cycle → udf_err stays 1.
- flush with 3 entries in RAM and 1 read in flight → next cycle level=0, rd_vld=0; the late ram_do is not loaded; the next push reads back correctly from address 0.

Source files
------------

// File: rtl/ramrwp_pbuf.sv
// Two-entry show-ahead register FIFO that holds words returned by the RAM.
// The head entry is always presented on head; a load and a pop can share a cycle.
module ramrwp_pbuf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [1:0]       cnt,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] ent0_reg, ent1_reg;
  logic [1:0]       cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_reg <= '0;
      ent1_reg <= '0;
      cnt_reg  <= '0;
    end else if (flush) begin
      ent0_reg <= '0;
      ent1_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      case ({load, pop})
        2'b10: begin
          if (cnt_reg == 2'd0) ent0_reg <= din;
          else                 ent1_reg <= din;
          cnt_reg <= cnt_reg + 2'd1;
        end
        2'b01: begin
          ent0_reg <= ent1_reg;
          cnt_reg  <= cnt_reg - 2'd1;
        end
        2'b11: begin
          // count is unchanged; with one entry the new word goes straight to the head
          if (cnt_reg == 2'd1) begin
            ent0_reg <= din;
          end else begin
            ent0_reg <= ent1_reg;
            ent1_reg <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign cnt  = cnt_reg;
  assign head = ent0_reg;

endmodule

// File: rtl/ramrwp_fifoctl.sv
// FIFO controller mastering an external two-port RAM with 1-cycle read latency,
// presenting a show-ahead pop interface through a 2-entry prefetch buffer.
module ramrwp_fifoctl #(
  parameter int ADDRBIT = 9,
  parameter int DEPTH   = 512,
  parameter int WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [WIDTH-1:0]   pdat,
  output logic               full,
  input  logic               pop,
  output logic               rd_vld,
  output logic [WIDTH-1:0]   rd_dat,
  output logic [ADDRBIT+1:0] level,
  output logic               ovf_err,
  output logic               udf_err,
  input  logic               clr_err,
  output logic [ADDRBIT-1:0] ram_wa,
  output logic               ram_we,
  output logic [WIDTH-1:0]   ram_di,
  output logic [ADDRBIT-1:0] ram_ra,
  output logic               ram_re,
  input  logic [WIDTH-1:0]   ram_do
);

  localparam int CW = ADDRBIT + 1;
  localparam int LW = ADDRBIT + 2;

  logic [ADDRBIT-1:0] wptr_reg, rptr_reg;
  logic [CW-1:0]      ram_cnt_reg;
  logic               inflight_reg;
  logic               ovf_reg, udf_reg;
  logic [1:0]         pbuf_cnt;
  logic               pop_ok;
  logic [2:0]         slots;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [ADDRBIT-1:0] wrap_inc(input logic [ADDRBIT-1:0] p);
    return (p == ADDRBIT'(DEPTH - 1)) ? '0 : p + ADDRBIT'(1);
  endfunction

  assign full   = (ram_cnt_reg == CW'(DEPTH));
  assign pop_ok = pop & rd_vld;
  assign slots  = {1'b0, pbuf_cnt} + {2'b00, inflight_reg} - {2'b00, pop_ok};

  assign ram_we = push & ~full & ~flush;
  assign ram_wa = wptr_reg;
  assign ram_di = pdat;
  assign ram_re = (ram_cnt_reg != '0) & (slots < 3'd2) & ~flush;
  assign ram_ra = rptr_reg;

  assign rd_vld  = (pbuf_cnt != 2'd0);
  assign level   = LW'(ram_cnt_reg) + LW'(inflight_reg) + LW'(pbuf_cnt);
  assign ovf_err = ovf_reg;
  assign udf_err = udf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      ram_cnt_reg  <= '0;
      inflight_reg <= 1'b0;
    end else if (flush) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      ram_cnt_reg  <= '0;
      inflight_reg <= 1'b0;
    end else begin
      if (ram_we) wptr_reg <= wrap_inc(wptr_reg);
      if (ram_re) rptr_reg <= wrap_inc(rptr_reg);
      inflight_reg <= ram_re;
      case ({ram_we, ram_re})
        2'b10:   ram_cnt_reg <= ram_cnt_reg + CW'(1);
        2'b01:   ram_cnt_reg <= ram_cnt_reg - CW'(1);
        default: ;
      endcase
    end
  end

  // Sticky errors survive flush; a new error beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      ovf_reg <= (push & full & ~flush) | (ovf_reg & ~clr_err);
      udf_reg <= (pop & ~rd_vld & ~flush) | (udf_reg & ~clr_err);
    end
  end

  ramrwp_pbuf #(.WIDTH(WIDTH)) u_pbuf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .load  (inflight_reg),
    .din   (ram_do),
    .pop   (pop_ok),
    .cnt   (pbuf_cnt),
    .head  (rd_dat)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    assert (!(ram_re && ram_we && (ram_wa == ram_ra)))
      else $error("ramrwp_fifoctl: read/write collision at address %0d", ram_wa);
  end
`endif

endmodule

// File: tb/tb_ramrwp_fifoctl.sv
// Directed bench for ramrwp_fifoctl: vector table plus multi-cycle sequences,
// with a second DEPTH=5 instance for streaming and pointer-wrap traffic.
module tb_ramrwp_fifoctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // default build (ADDRBIT=9, DEPTH=512)
  logic        rst_n, flush, push, pop, clr_err;
  logic [31:0] pdat, rd_dat, ram_di, ram_do;
  logic        full, rd_vld, ovf_err, udf_err, ram_we, ram_re;
  logic [10:0] level;
  logic [8:0]  ram_wa, ram_ra;

  ramrwp_fifoctl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .pdat(pdat),
    .full(full), .pop(pop), .rd_vld(rd_vld), .rd_dat(rd_dat), .level(level),
    .ovf_err(ovf_err), .udf_err(udf_err), .clr_err(clr_err),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_do(ram_do)
  );

  logic [31:0] mem [0:511];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ram_do <= mem[ram_ra];
  end

  // non-power-of-2 build (ADDRBIT=3, DEPTH=5)
  logic        s_push, s_pop, s_full, s_vld, s_ovf, s_udf, s_we, s_re;
  logic [31:0] s_pdat, s_dat, s_di, s_do;
  logic [4:0]  s_lvl;
  logic [2:0]  s_wa, s_ra;

  ramrwp_fifoctl #(.ADDRBIT(3), .DEPTH(5), .WIDTH(32)) dut5 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .push(s_push), .pdat(s_pdat),
    .full(s_full), .pop(s_pop), .rd_vld(s_vld), .rd_dat(s_dat), .level(s_lvl),
    .ovf_err(s_ovf), .udf_err(s_udf), .clr_err(1'b0),
    .ram_wa(s_wa), .ram_we(s_we), .ram_di(s_di),
    .ram_ra(s_ra), .ram_re(s_re), .ram_do(s_do)
  );

  logic [31:0] mem5 [0:7];
  always @(posedge clk) begin
    if (s_we) mem5[s_wa] <= s_di;
    if (s_re) s_do <= mem5[s_ra];
  end

  int mon_bad = 0;
  always @(negedge clk) begin
    if ((ram_we && ram_re && ram_wa == ram_ra) || (s_we && s_re && s_wa == s_ra) || (s_lvl > 5'd7))
      mon_bad <= mon_bad + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        push;
    logic [31:0] pdat;
    logic        pop;
    logic        clr;
    logic        e_we;
    logic [8:0]  e_wa;
    logic        e_re;
    logic [8:0]  e_ra;
    logic        e_vld;
    logic [31:0] e_dat;
    logic [10:0] e_lvl;
    logic        e_udf;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q [$];
    int n, got, pops;

    // push, pdat, pop, clr | we, wa, re, ra, vld, dat, lvl, udf
    tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 9'd0, 1'b0, 9'd0, 1'b0, 32'h0,         11'd0, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 9'd0, 1'b0, 32'h0,         11'd1, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 32'h0,         11'd1, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b1, 32'hA5A5_0001, 11'd1, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 32'h0,         11'd0, 1'b0};
    tbl[5]  = '{1'b1, 32'hB000_0000, 1'b0, 1'b0, 1'b1, 9'd1, 1'b0, 9'd0, 1'b0, 32'h0,         11'd0, 1'b0};
    tbl[6]  = '{1'b1, 32'hB000_0001, 1'b0, 1'b0, 1'b1, 9'd2, 1'b1, 9'd1, 1'b0, 32'h0,         11'd1, 1'b0};
    tbl[7]  = '{1'b1, 32'hB000_0002, 1'b0, 1'b0, 1'b1, 9'd3, 1'b1, 9'd2, 1'b0, 32'h0,         11'd2, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 9'd0, 1'b1, 9'd3, 1'b1, 32'hB000_0000, 11'd3, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b1, 32'hB000_0001, 11'd2, 1'b0};
    tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b1, 32'hB000_0002, 11'd1, 1'b0};
    tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 32'h0,         11'd0, 1'b0};
    tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 32'h0,         11'd0, 1'b1};
    tbl[13] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 32'h0,         11'd0, 1'b1};
    tbl[14] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 32'h0,         11'd0, 1'b0};

    rst_n = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; pdat = '0;
    s_push = 1'b0; s_pop = 1'b0; s_pdat = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_full", full, 0);   chk("rst_vld", rd_vld, 0); chk("rst_lvl", level, 0);
    chk("rst_we", ram_we, 0);   chk("rst_re", ram_re, 0);  chk("rst_dat", rd_dat, 0);
    chk("rst_ovf", ovf_err, 0); chk("rst_udf", udf_err, 0);
    rst_n = 1'b1;
    tick();

    // ---- vector table: single-entry latency, back-to-back, underflow/clear
    for (int i = 0; i < 15; i++) begin
      push = tbl[i].push; pdat = tbl[i].pdat; pop = tbl[i].pop; clr_err = tbl[i].clr;
      #1;
      chk($sformatf("v%0d_we", i), ram_we, tbl[i].e_we);
      if (tbl[i].e_we) chk($sformatf("v%0d_wa", i), ram_wa, tbl[i].e_wa);
      chk($sformatf("v%0d_re", i), ram_re, tbl[i].e_re);
      if (tbl[i].e_re) chk($sformatf("v%0d_ra", i), ram_ra, tbl[i].e_ra);
      chk($sformatf("v%0d_vld", i), rd_vld, tbl[i].e_vld);
      if (tbl[i].e_vld) chk($sformatf("v%0d_dat", i), rd_dat, tbl[i].e_dat);
      chk($sformatf("v%0d_lvl", i), level, tbl[i].e_lvl);
      chk($sformatf("v%0d_udf", i), udf_err, tbl[i].e_udf);
      tick();
    end
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;

    // ---- flush with 3 in RAM, 1 read in flight, 1 prefetched
    for (int k = 0; k < 6; k++) begin
      push = 1'b1; pdat = 32'hE000_0000 + k; pop = (k == 5);
      #1;
      if (k == 5) chk("fl_head0", rd_dat, 32'hE000_0000);
      tick();
    end
    push = 1'b0; pop = 1'b0;
    #1;
    chk("fl_pre_lvl", level, 5);
    chk("fl_pre_dat", rd_dat, 32'hE000_0001);
    flush = 1'b1; push = 1'b1; pop = 1'b1;
    #1;
    chk("fl_we", ram_we, 0);
    chk("fl_re", ram_re, 0);
    tick();
    flush = 1'b0; push = 1'b0; pop = 1'b0;
    #1;
    chk("fl_lvl", level, 0); chk("fl_vld", rd_vld, 0); chk("fl_dat", rd_dat, 0);
    tick();
    chk("fl_late", rd_vld, 0);
    push = 1'b1; pdat = 32'hF00D_0001;
    #1;
    chk("fl_we2", ram_we, 1); chk("fl_wa2", ram_wa, 0);
    tick();
    push = 1'b0;
    #1;
    chk("fl_re2", ram_re, 1); chk("fl_ra2", ram_ra, 0);
    n = 0;
    while (!rd_vld && n < 8) begin tick(); n++; end
    chk("fl_rb_vld", rd_vld, 1);
    chk("fl_rb_dat", rd_dat, 32'hF00D_0001);
    pop = 1'b1;
    tick();
    pop = 1'b0;

    // ---- async reset in the middle of traffic
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("mr_udf_set", udf_err, 1);
    for (int k = 0; k < 3; k++) begin push = 1'b1; pdat = 32'h7000_0000 + k; tick(); end
    push = 1'b0; rst_n = 1'b0;
    #1;
    chk("mr_lvl", level, 0); chk("mr_vld", rd_vld, 0); chk("mr_we", ram_we, 0);
    chk("mr_re", ram_re, 0); chk("mr_udf", udf_err, 0); chk("mr_full", full, 0);
    tick();
    chk("mr_lvl2", level, 0); chk("mr_ovf", ovf_err, 0);
    rst_n = 1'b1;
    tick();

    // ---- fill to DEPTH+2, overflow, push-while-full with read, drain, wrap
    for (int k = 0; k < 514; k++) begin
      push = 1'b1; pdat = 32'h1000_0000 + k;
      #1;
      if (k == 513) chk("fill_full_pre", full, 0);
      tick();
    end
    pdat = 32'hDEAD_BEEF;
    #1;
    chk("fill_full", full, 1); chk("fill_lvl", level, 514); chk("ovf_we", ram_we, 0);
    tick();
    chk("ovf_set", ovf_err, 1); chk("ovf_lvl", level, 514);
    pop = 1'b1;
    #1;
    chk("pwf_we", ram_we, 0); chk("pwf_re", ram_re, 1); chk("pwf_dat", rd_dat, 32'h1000_0000);
    tick();
    push = 1'b0; pop = 1'b0; clr_err = 1'b1;
    #1;
    chk("pwf_lvl", level, 513);
    tick();
    clr_err = 1'b0;
    chk("ovf_clr", ovf_err, 0);
    got = 1; n = 0;
    while (got < 514 && n < 3000) begin
      pop = rd_vld;
      if (rd_vld) begin
        chk($sformatf("drain%0d", got), rd_dat, 32'h1000_0000 + got);
        got++;
      end
      tick();
      n++;
    end
    pop = 1'b0;
    chk("drain_cnt", got, 514);
    #1;
    chk("drain_lvl", level, 0);
    push = 1'b1; pdat = 32'hC0DE_0002;
    #1;
    chk("wrap_we", ram_we, 1); chk("wrap_wa", ram_wa, 2);
    tick();
    push = 1'b0;
    #1;
    chk("wrap_re", ram_re, 1); chk("wrap_ra", ram_ra, 2);
    tick();

    // ---- DEPTH=5: continuous push+pop, then random traffic
    pops = 0;
    for (int c = 0; c < 2000; c++) begin
      s_push = 1'b1; s_pdat = $urandom;
      if (!s_full) q.push_back(s_pdat);
      s_pop = s_vld;
      if (s_vld) begin
        if (c >= 10) pops++;
        chk("strm_dat", s_dat, q.pop_front());
      end
      tick();
    end
    chk("strm_rate", pops, 1990);
    chk("strm_ovf", s_ovf, 0);
    for (int c = 0; c < 1000; c++) begin
      s_push = ($urandom_range(0, 3) != 0); s_pdat = $urandom;
      if (s_push && !s_full) q.push_back(s_pdat);
      s_pop = s_vld & ($urandom_range(0, 1) == 1);
      if (s_pop) chk("rand_dat", s_dat, q.pop_front());
      tick();
    end
    s_push = 1'b0; n = 0;
    while (q.size() > 0 && n < 100) begin
      s_pop = s_vld;
      if (s_vld) chk("rdrain_dat", s_dat, q.pop_front());
      tick();
      n++;
    end
    s_pop = 1'b0;
    chk("rdrain_left", q.size(), 0);
    chk("strm_udf", s_udf, 0);
    tick();
    chk("monitor", mon_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
